keypad_scan_ctrl: RTL

//   Scan scheduler and event front-end for the 4x4 matrix keypad.
//   - Drives one column low at a time, with a programmable settle dwell, then samples the rows.
//   - Debounces full-scan results across scans.
//   - Delivers one key-press event per press over a valid/ready handshake to the game control logic.

---
 rtl/keypad_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// Scan scheduler, debouncer and event front-end for a 4x4 matrix keypad.
// Optional auto-repeat of held keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] r,
    output logic [3:0] c,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    c_q, c_d;
    logic          acc_hit_q, acc_hit_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic          prev_hit_q, prev_hit_d;
    logic [3:0]    prev_code_q, prev_code_d;
    logic [SW-1:0] stable_q, stable_d;
    logic          held_q, held_d;
    logic [3:0]    held_code_q, held_code_d;
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;
    logic          ovr_q, ovr_d;

    logic       sample;
    logic       col_ok;
    logic [1:0] col_idx;
    logic       row_hit;
    logic [1:0] row_idx;
    logic       cur_hit;
    logic [3:0] cur_code;
    logic       scan_done;
    logic       settled;
    logic       press_ev;
    logic       rep_ev;
    logic       ev;

    function automatic logic [3:0] key_map(input logic [1:0] col,
                                           input logic [1:0] row);
        logic [3:0] k;
        case ({col, row})
            4'h0:    k = 4'd1;
            4'h1:    k = 4'd4;
            4'h2:    k = 4'd7;
            4'h3:    k = 4'd14;
            4'h4:    k = 4'd2;
            4'h5:    k = 4'd5;
            4'h6:    k = 4'd8;
            4'h7:    k = 4'd0;
            4'h8:    k = 4'd3;
            4'h9:    k = 4'd6;
            4'hA:    k = 4'd9;
            4'hB:    k = 4'd15;
            4'hC:    k = 4'd10;
            4'hD:    k = 4'd11;
            4'hE:    k = 4'd12;
            default: k = 4'd13;
        endcase
        return k;
    endfunction

    assign sample = (cnt_q == CW'(SETTLE_CYCLES - 1));

    // Decode the driven column from the one-cold drive pattern
    always_comb begin
        col_ok  = 1'b1;
        col_idx = 2'd0;
        case (c_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
    end

    // Lowest closed row in the driven column
    always_comb begin
        row_hit = 1'b0;
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) begin
                row_hit = 1'b1;
                row_idx = 2'(i);
            end
        end
    end

    // Next column and dwell count; an illegal drive pattern restarts at col0
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        c_d   = c_q;
        if (!col_ok) begin
            cnt_d = '0;
            c_d   = 4'b1110;
        end else if (sample) begin
            cnt_d = '0;
            c_d   = {c_q[2:0], c_q[3]};
        end
    end

    // Scan result including this sample; col0 starts a fresh scan
    always_comb begin
        if (col_idx == 2'd0 || !acc_hit_q) begin
            cur_hit  = row_hit;
            cur_code = row_hit ? key_map(col_idx, row_idx) : 4'd0;
        end else begin
            cur_hit  = acc_hit_q;
            cur_code = acc_code_q;
        end
        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        if (sample && col_ok) begin
            acc_hit_d  = cur_hit;
            acc_code_d = cur_code;
        end
    end

    assign scan_done = sample && col_ok && (col_idx == 2'd3);

    // Debounce across full scans and detect new presses
    always_comb begin
        prev_hit_d  = prev_hit_q;
        prev_code_d = prev_code_q;
        stable_d    = stable_q;
        held_d      = held_q;
        held_code_d = held_code_q;
        settled     = 1'b0;
        press_ev    = 1'b0;
        if (scan_done) begin
            prev_hit_d  = cur_hit;
            prev_code_d = cur_code;
            if (cur_hit == prev_hit_q && cur_code == prev_code_q) begin
                if (stable_q != SW'(DEBOUNCE_SCANS))
                    stable_d = stable_q + SW'(1);
            end else begin
                stable_d = SW'(1);
            end
            settled = (stable_d == SW'(DEBOUNCE_SCANS));
            if (settled) begin
                held_d = cur_hit;
                if (cur_hit) begin
                    held_code_d = cur_code;
                    press_ev    = !held_q || (cur_code != held_code_q);
                end
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_q, rep_d;

    // Count stable held scans and fire a repeat every REPEAT_SCANS of them
    always_comb begin
        rep_d  = rep_q;
        rep_ev = 1'b0;
        if (scan_done) begin
            if (press_ev || !settled || !cur_hit || !held_q) begin
                rep_d = '0;
            end else if (rep_q + RW'(1) == RW'(REPEAT_SCANS)) begin
                rep_d  = '0;
                rep_ev = 1'b1;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end
    end

    // Repeat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    logic unused_rep;
    assign unused_rep = (REPEAT_SCANS > 0);
    assign rep_ev     = 1'b0;
`endif

    assign ev = press_ev || rep_ev;

    // Event hold register: keep pending event, drop newcomers with overrun
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovr_d   = 1'b0;
        if (valid_q && key_ready) begin
            if (ev) code_d  = cur_code;
            else    valid_d = 1'b0;
        end else if (valid_q) begin
            ovr_d = ev;
        end else if (ev) begin
            valid_d = 1'b1;
            code_d  = cur_code;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            c_q         <= 4'b1110;
            acc_hit_q   <= 1'b0;
            acc_code_q  <= 4'd0;
            prev_hit_q  <= 1'b0;
            prev_code_q <= 4'd0;
            stable_q    <= '0;
            held_q      <= 1'b0;
            held_code_q <= 4'd0;
            valid_q     <= 1'b0;
            code_q      <= 4'd0;
            ovr_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            acc_hit_q   <= acc_hit_d;
            acc_code_q  <= acc_code_d;
            prev_hit_q  <= prev_hit_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            ovr_q       <= ovr_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        c         = c_q;
        key_code  = code_q;
        key_valid = valid_q;
        key_held  = held_q;
        overrun   = ovr_q;
    end

endmodule
